hpu_cmd_tracker: RTL and testbench

- Per-cluster stage that sits between the cluster's HPU command arbiter and the SoC-level command unit.
- Accepts one command per cycle from an already-arbitrated core request port.
- Allocates a free local_cmd_id for the issuing core (up to NUM_HPU_CMDS in flight per core), stamps the full pspin_cmd_id_t, and forwards a registered pspin_cmd_req_t downstream.
- Consumes pspin_cmd_resp_t completions, frees the slot, and pulses per-core completion back to the HPUs.

---
 rtl/hpu_cmd_tracker.sv | 191 +++++++++++++++++++
 tb/tb_hpu_cmd_tracker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_cmd_tracker.sv
// hpu_cmd_tracker_pkg: system sizing and the command/response payload types
// exchanged between the cluster command stage and the SoC command unit.
package hpu_cmd_tracker_pkg;

  localparam int unsigned NUM_CLUSTERS       = 4;
  localparam int unsigned NUM_CORES          = 8;
  localparam int unsigned NUM_HPU_CMDS       = 4;
  localparam int unsigned NUM_CMD_INTERFACES = 3;

  localparam int unsigned CW      = (NUM_CLUSTERS       > 1) ? $clog2(NUM_CLUSTERS)       : 1;
  localparam int unsigned KW      = (NUM_CORES          > 1) ? $clog2(NUM_CORES)          : 1;
  localparam int unsigned LW      = (NUM_HPU_CMDS       > 1) ? $clog2(NUM_HPU_CMDS)       : 1;
  localparam int unsigned IW      = (NUM_CMD_INTERFACES > 1) ? $clog2(NUM_CMD_INTERFACES) : 1;
  localparam int unsigned DESCR_W = 608;

  typedef logic [DESCR_W-1:0] pspin_cmd_descr_t;

  typedef struct packed {
    logic [CW-1:0] cluster_id;
    logic [KW-1:0] core_id;
    logic [LW-1:0] local_cmd_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    logic [IW-1:0]    intf_id;
    logic [7:0]       cmd_type;
    pspin_cmd_id_t    cmd_id;
    pspin_cmd_descr_t descr;
  } pspin_cmd_req_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
  } pspin_cmd_resp_t;

endpackage

// hpu_cmd_tracker: allocates per-core local command ids, stamps the global
// cmd_id, forwards commands through one registered pipeline stage and retires
// them on completion responses.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cluster_id_i              static id of this cluster
//   req_*                     arbitrated core command (valid/ready), allocated id out
//   cmd_valid_o/ready_i/cmd_o registered downstream command
//   resp_valid_i/resp_i       completion (always accepted)
//   done_o/done_local_id_o    registered one-cycle completion pulse per core
//   core_full_o/inflight_o    per-core full flag and slot bitmap
//   resp_err_o                pulse on a response for a foreign cluster or free slot
module hpu_cmd_tracker
  import hpu_cmd_tracker_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [CW-1:0]                      cluster_id_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [KW-1:0]                      req_core_id_i,
  input  logic [IW-1:0]                      req_intf_id_i,
  input  logic [7:0]                         req_cmd_type_i,
  input  pspin_cmd_descr_t                   req_descr_i,
  output logic [LW-1:0]                      req_local_id_o,
  output logic                               cmd_valid_o,
  input  logic                               cmd_ready_i,
  output pspin_cmd_req_t                     cmd_o,
  input  logic                               resp_valid_i,
  input  pspin_cmd_resp_t                    resp_i,
  output logic [NUM_CORES-1:0]               done_o,
  output logic [LW-1:0]                      done_local_id_o,
  output logic [NUM_CORES-1:0]               core_full_o,
  output logic [NUM_CORES*NUM_HPU_CMDS-1:0]  inflight_o,
  output logic                               resp_err_o
);

  // Slot bitmap, core-major so the flattened index is core*NUM_HPU_CMDS+local.
  logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] r_bitmap;
  logic [NUM_CORES-1:0][NUM_HPU_CMDS-1:0] w_bitmap_nxt;

  logic                   r_cmd_valid;
  pspin_cmd_req_t         r_cmd;
  logic [NUM_CORES-1:0]   r_done;
  logic [LW-1:0]          r_done_local_id;
  logic                   r_resp_err;

  logic [NUM_HPU_CMDS-1:0] w_free_vec;
  logic [LW-1:0]           w_alloc_id;
  logic                    w_found;
  logic                    w_accept;
  logic [KW-1:0]           w_resp_core;
  logic [LW-1:0]           w_resp_local;
  logic                    w_resp_hit;
  pspin_cmd_req_t          w_cmd_new;

  // Lowest-index free slot of the requesting core (pre-clear view of the bitmap).
  assign w_free_vec = ~r_bitmap[req_core_id_i];

  always_comb begin
    w_alloc_id = '0;
    w_found    = 1'b0;
    for (int l = 0; l < int'(NUM_HPU_CMDS); l++) begin
      if (w_free_vec[l] && !w_found) begin
        w_alloc_id = LW'(l);
        w_found    = 1'b1;
      end
    end
  end

  // Accept only when a slot is free and the output stage drains this cycle.
  assign req_ready_o    = w_found && (!r_cmd_valid || cmd_ready_i);
  assign req_local_id_o = w_alloc_id;
  assign w_accept       = req_valid_i && req_ready_o;

  // A response retires a slot only if it targets this cluster and the slot is busy.
  assign w_resp_core  = resp_i.cmd_id.core_id;
  assign w_resp_local = resp_i.cmd_id.local_cmd_id;
  assign w_resp_hit   = resp_valid_i
                        && (resp_i.cmd_id.cluster_id == cluster_id_i)
                        && r_bitmap[w_resp_core][w_resp_local];

  // Set and clear never collide: allocation only ever picks a free bit.
  always_comb begin
    w_bitmap_nxt = r_bitmap;
    if (w_accept) begin
      w_bitmap_nxt[req_core_id_i][w_alloc_id] = 1'b1;
    end
    if (w_resp_hit) begin
      w_bitmap_nxt[w_resp_core][w_resp_local] = 1'b0;
    end
  end

  always_comb begin
    w_cmd_new                     = '0;
    w_cmd_new.intf_id             = req_intf_id_i;
    w_cmd_new.cmd_type            = req_cmd_type_i;
    w_cmd_new.cmd_id.cluster_id   = cluster_id_i;
    w_cmd_new.cmd_id.core_id      = req_core_id_i;
    w_cmd_new.cmd_id.local_cmd_id = w_alloc_id;
    w_cmd_new.descr               = req_descr_i;
  end

  // Slot bitmap register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitmap <= '0;
    end else begin
      r_bitmap <= w_bitmap_nxt;
    end
  end

  // Downstream pipeline stage: load on accept, hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b1;
      r_cmd       <= w_cmd_new;
    end else if (cmd_ready_i) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Completion and error pulses, one cycle after the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done          <= '0;
      r_done_local_id <= '0;
      r_resp_err      <= 1'b0;
    end else begin
      r_done     <= '0;
      r_resp_err <= resp_valid_i && !w_resp_hit;
      if (w_resp_hit) begin
        r_done[w_resp_core] <= 1'b1;
        r_done_local_id     <= w_resp_local;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      core_full_o[c] = &r_bitmap[c];
    end
  end

  assign inflight_o      = r_bitmap;
  assign cmd_valid_o     = r_cmd_valid;
  assign cmd_o           = r_cmd;
  assign done_o          = r_done;
  assign done_local_id_o = r_done_local_id;
  assign resp_err_o      = r_resp_err;

endmodule

// File: tb/tb_hpu_cmd_tracker.sv
// Directed bench for hpu_cmd_tracker: inputs change 1ns after posedge,
// outputs are checked 2ns after the drive (well before the next edge).
module tb_hpu_cmd_tracker;
  import hpu_cmd_tracker_pkg::*;

  logic                              clk_i = 1'b0;
  logic                              rst_i;
  logic [CW-1:0]                     cluster_id_i;
  logic                              req_valid_i;
  logic                              req_ready_o;
  logic [KW-1:0]                     req_core_id_i;
  logic [IW-1:0]                     req_intf_id_i;
  logic [7:0]                        req_cmd_type_i;
  pspin_cmd_descr_t                  req_descr_i;
  logic [LW-1:0]                     req_local_id_o;
  logic                              cmd_valid_o;
  logic                              cmd_ready_i;
  pspin_cmd_req_t                    cmd_o;
  logic                              resp_valid_i;
  pspin_cmd_resp_t                   resp_i;
  logic [NUM_CORES-1:0]              done_o;
  logic [LW-1:0]                     done_local_id_o;
  logic [NUM_CORES-1:0]              core_full_o;
  logic [NUM_CORES*NUM_HPU_CMDS-1:0] inflight_o;
  logic                              resp_err_o;

  int n_checks = 0;
  int n_errors = 0;

  pspin_cmd_descr_t d1, d2;

  hpu_cmd_tracker u_dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cluster_id_i    (cluster_id_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_core_id_i   (req_core_id_i),
    .req_intf_id_i   (req_intf_id_i),
    .req_cmd_type_i  (req_cmd_type_i),
    .req_descr_i     (req_descr_i),
    .req_local_id_o  (req_local_id_o),
    .cmd_valid_o     (cmd_valid_o),
    .cmd_ready_i     (cmd_ready_i),
    .cmd_o           (cmd_o),
    .resp_valid_i    (resp_valid_i),
    .resp_i          (resp_i),
    .done_o          (done_o),
    .done_local_id_o (done_local_id_o),
    .core_full_o     (core_full_o),
    .inflight_o      (inflight_o),
    .resp_err_o      (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_req(input int core, input int intf, input int ctype, input pspin_cmd_descr_t d);
    req_valid_i    = 1'b1;
    req_core_id_i  = KW'(core);
    req_intf_id_i  = IW'(intf);
    req_cmd_type_i = 8'(ctype);
    req_descr_i    = d;
  endtask

  task automatic drive_resp(input int cl, input int core, input int loc);
    resp_valid_i                = 1'b1;
    resp_i.cmd_id.cluster_id    = CW'(cl);
    resp_i.cmd_id.core_id       = KW'(core);
    resp_i.cmd_id.local_cmd_id  = LW'(loc);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_valid"}, 64'(cmd_valid_o), 64'd0);
    check({pfx, "_cmd_id"},    64'(cmd_o.cmd_id), 64'd0);
    check({pfx, "_cmd_type"},  64'(cmd_o.cmd_type), 64'd0);
    check({pfx, "_descr_lo"},  cmd_o.descr[63:0], 64'd0);
    check({pfx, "_inflight"},  64'(inflight_o), 64'd0);
    check({pfx, "_core_full"}, 64'(core_full_o), 64'd0);
    check({pfx, "_done"},      64'(done_o), 64'd0);
    check({pfx, "_done_id"},   64'(done_local_id_o), 64'd0);
    check({pfx, "_resp_err"},  64'(resp_err_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = {19{32'hDEAD_0001}};
    d2 = {19{32'hBEEF_0002}};
    rst_i          = 1'b1;
    cluster_id_i   = 2'd2;
    req_valid_i    = 1'b0;
    req_core_id_i  = '0;
    req_intf_id_i  = '0;
    req_cmd_type_i = '0;
    req_descr_i    = '0;
    cmd_ready_i    = 1'b1;
    resp_valid_i   = 1'b0;
    resp_i         = '0;

    tick(); tick();
    check_reset_outputs("rst");
    rst_i = 1'b0;
    tick();

    // Single issue: core 3, intf 1, type 0x05 -> cmd_id {2,3,0} = 0x4C
    drive_req(3, 1, 8'h05, d1);
    settle();
    check("single_ready", 64'(req_ready_o), 64'd1);
    check("single_id", 64'(req_local_id_o), 64'd0);
    tick();
    req_valid_i = 1'b0;
    settle();
    check("single_valid", 64'(cmd_valid_o), 64'd1);
    check("single_cmd_id", 64'(cmd_o.cmd_id), 64'h4C);
    check("single_intf", 64'(cmd_o.intf_id), 64'd1);
    check("single_type", 64'(cmd_o.cmd_type), 64'h05);
    check("single_descr", 64'(cmd_o.descr == d1), 64'd1);
    check("single_inflight", 64'(inflight_o), 64'h0000_1000);
    tick();
    check("single_drained", 64'(cmd_valid_o), 64'd0);

    // Fill core 5 back to back
    for (int i = 0; i < 4; i++) begin
      drive_req(5, 0, 8'h10 + i, d2);
      settle();
      check($sformatf("full_ready%0d", i), 64'(req_ready_o), 64'd1);
      check($sformatf("full_id%0d", i), 64'(req_local_id_o), 64'(i));
      tick();
    end
    settle();
    check("full_ready5", 64'(req_ready_o), 64'd0);
    check("full_flag", 64'(core_full_o), 64'h20);
    check("full_inflight", 64'(inflight_o), 64'h00F0_1000);
    check("full_last_id", 64'(cmd_o.cmd_id), 64'h57);
    req_valid_i = 1'b0;
    tick();

    // Free {2,5,1} and reuse id 1
    drive_resp(2, 5, 1);
    tick();
    resp_valid_i = 1'b0;
    settle();
    check("free_done", 64'(done_o), 64'h20);
    check("free_done_id", 64'(done_local_id_o), 64'd1);
    check("free_err", 64'(resp_err_o), 64'd0);
    check("free_inflight", 64'(inflight_o), 64'h00D0_1000);
    check("free_not_full", 64'(core_full_o), 64'h00);
    drive_req(5, 2, 8'h33, d1);
    settle();
    check("reuse_ready", 64'(req_ready_o), 64'd1);
    check("reuse_id", 64'(req_local_id_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    settle();
    check("reuse_done_clear", 64'(done_o), 64'h00);
    check("reuse_cmd_id", 64'(cmd_o.cmd_id), 64'h55);
    tick();

    // Backpressure: command for core 0 held for 5 cycles
    cmd_ready_i = 1'b0;
    drive_req(0, 2, 8'h11, d1);
    settle();
    check("bp_first_ready", 64'(req_ready_o), 64'd1);
    tick();
    drive_req(0, 1, 8'h22, d2);
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("bp_ready%0d", i), 64'(req_ready_o), 64'd0);
      check($sformatf("bp_valid%0d", i), 64'(cmd_valid_o), 64'd1);
      check($sformatf("bp_cmd_id%0d", i), 64'(cmd_o.cmd_id), 64'h40);
      check($sformatf("bp_type%0d", i), 64'(cmd_o.cmd_type), 64'h11);
      tick();
    end
    cmd_ready_i = 1'b1;
    settle();
    check("bp_release_ready", 64'(req_ready_o), 64'd1);
    check("bp_release_id", 64'(req_local_id_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    settle();
    check("bp_next_valid", 64'(cmd_valid_o), 64'd1);
    check("bp_next_cmd_id", 64'(cmd_o.cmd_id), 64'h41);
    check("bp_next_type", 64'(cmd_o.cmd_type), 64'h22);
    check("bp_next_intf", 64'(cmd_o.intf_id), 64'd1);
    check("bp_next_descr", 64'(cmd_o.descr == d2), 64'd1);
    tick();
    check("bp_drained", 64'(cmd_valid_o), 64'd0);
    check("bp_inflight", 64'(inflight_o), 64'h00F0_1003);

    // Illegal: foreign cluster, then free slot {2,0,3}
    drive_resp(1, 3, 0);
    tick();
    resp_valid_i = 1'b0;
    settle();
    check("ill_cl_err", 64'(resp_err_o), 64'd1);
    check("ill_cl_done", 64'(done_o), 64'h00);
    check("ill_cl_inflight", 64'(inflight_o), 64'h00F0_1003);
    tick();
    check("ill_cl_err_clear", 64'(resp_err_o), 64'd0);
    drive_resp(2, 0, 3);
    tick();
    resp_valid_i = 1'b0;
    settle();
    check("ill_free_err", 64'(resp_err_o), 64'd1);
    check("ill_free_done", 64'(done_o), 64'h00);
    check("ill_free_inflight", 64'(inflight_o), 64'h00F0_1003);
    tick();
    check("ill_free_err_clear", 64'(resp_err_o), 64'd0);

    // Collision: core 2 full, response {2,2,0} with a core 2 request
    for (int i = 0; i < 4; i++) begin
      drive_req(2, 0, 8'h40 + i, d1);
      tick();
    end
    drive_resp(2, 2, 0);
    settle();
    check("col_full", 64'(core_full_o), 64'h24);
    check("col_ready", 64'(req_ready_o), 64'd0);
    tick();
    resp_valid_i = 1'b0;
    settle();
    check("col_done", 64'(done_o), 64'h04);
    check("col_done_id", 64'(done_local_id_o), 64'd0);
    check("col_ready_next", 64'(req_ready_o), 64'd1);
    check("col_id_next", 64'(req_local_id_o), 64'd0);
    tick();
    req_valid_i = 1'b0;
    settle();
    check("col_cmd_id", 64'(cmd_o.cmd_id), 64'h48);
    check("col_inflight", 64'(inflight_o), 64'h00F0_1F03);

    // Reset with a held command and commands in flight
    cmd_ready_i = 1'b0;
    drive_req(1, 1, 8'h77, d2);
    tick();
    req_valid_i = 1'b0;
    drive_resp(2, 3, 0);
    rst_i = 1'b1;
    tick();
    resp_valid_i = 1'b0;
    settle();
    check_reset_outputs("mid_rst");
    rst_i = 1'b0;
    cmd_ready_i = 1'b1;
    tick();
    check("post_rst_done", 64'(done_o), 64'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
